axi_lite_cfg: RTL



---
 rtl/axi_lite_cfg_if.sv | 37 +++
 rtl/axi_lite_cfg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cfg_if.sv
// AXI4-Lite bus bundle between the PS general-purpose master and the fabric
// configuration register bank.
interface axi_lite_cfg_if;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_bready, axi_araddr, axi_arprot, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_bready, axi_araddr, axi_arprot, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );
endinterface

// File: rtl/axi_lite_cfg.sv
// AXI4-Lite slave register bank: REG_NUM 32-bit configuration registers driven
// as parallel outputs, with a one-cycle strobe on every committed write.
// Write and read channels run independent two-state handshake machines.
module axi_lite_cfg #(
  parameter int  ADDR_WIDTH = 12,
  parameter int  REG_NUM    = 8,
  localparam int IDX_W      = $clog2(REG_NUM)
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst_n,
  axi_lite_cfg_if.slave          s_axi,
  output logic [32*REG_NUM-1:0]  cfg_data,
  output logic                   cfg_wr,
  output logic [IDX_W-1:0]       cfg_idx
);

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]      regs [REG_NUM];
  wr_state_t        wr_state;
  rd_state_t        rd_state;

  // Independently latched halves of a write transaction
  logic             aw_held;
  logic             w_held;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_ok_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;

  // Address decode: word index from the low bits, in range only when every
  // significant bit above the index is zero
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             aw_ok;
  logic             ar_ok;
  assign aw_idx = s_axi.axi_awaddr[IDX_W+1:2];
  assign ar_idx = s_axi.axi_araddr[IDX_W+1:2];
  assign aw_ok  = (s_axi.axi_awaddr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign ar_ok  = (s_axi.axi_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);

  // Protection bits, byte offset and bits above the 4 KiB window carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_axi.axi_awprot, s_axi.axi_arprot,
                         s_axi.axi_awaddr[31:ADDR_WIDTH], s_axi.axi_awaddr[1:0],
                         s_axi.axi_araddr[31:ADDR_WIDTH], s_axi.axi_araddr[1:0]};

  // Commit fires on the edge where both halves are available, whether latched
  // earlier or handshaking right now
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic [IDX_W-1:0] cm_idx;
  logic             cm_ok;
  logic [31:0]      cm_data;
  logic [3:0]       cm_strb;
  assign aw_hs   = s_axi.axi_awvalid & s_axi.axi_awready;
  assign w_hs    = s_axi.axi_wvalid & s_axi.axi_wready;
  assign ar_hs   = s_axi.axi_arvalid & s_axi.axi_arready;
  assign commit  = (wr_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign cm_idx  = aw_hs ? aw_idx : aw_idx_q;
  assign cm_ok   = aw_hs ? aw_ok : aw_ok_q;
  assign cm_data = w_hs ? s_axi.axi_wdata : w_data_q;
  assign cm_strb = w_hs ? s_axi.axi_wstrb : w_strb_q;

  // Register storage: byte-masked update on an in-range commit
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (commit && cm_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (cm_strb[k]) regs[cm_idx][8*k +: 8] <= cm_data[8*k +: 8];
      end
    end
  end

  for (genvar i = 0; i < REG_NUM; i++) begin : g_cfg
    assign cfg_data[32*i +: 32] = regs[i];
  end

  // Write channel: accept AW and W in any order, commit, hold B until accepted
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      wr_state           <= W_IDLE;
      s_axi.axi_awready  <= 1'b0;
      s_axi.axi_wready   <= 1'b0;
      s_axi.axi_bvalid   <= 1'b0;
      s_axi.axi_bresp    <= RESP_OKAY;
      aw_held            <= 1'b0;
      w_held             <= 1'b0;
      aw_idx_q           <= '0;
      aw_ok_q            <= 1'b0;
      w_data_q           <= '0;
      w_strb_q           <= '0;
      cfg_wr             <= 1'b0;
      cfg_idx            <= '0;
    end else begin
      cfg_wr <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (commit) begin
            wr_state          <= W_RESP;
            s_axi.axi_awready <= 1'b0;
            s_axi.axi_wready  <= 1'b0;
            s_axi.axi_bvalid  <= 1'b1;
            s_axi.axi_bresp   <= cm_ok ? RESP_OKAY : RESP_SLVERR;
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            if (cm_ok && cm_strb != 4'b0000) begin
              cfg_wr  <= 1'b1;
              cfg_idx <= cm_idx;
            end
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_q <= aw_idx;
              aw_ok_q  <= aw_ok;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= s_axi.axi_wdata;
              w_strb_q <= s_axi.axi_wstrb;
            end
            s_axi.axi_awready <= !(aw_held || aw_hs);
            s_axi.axi_wready  <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (s_axi.axi_bready) begin
            wr_state          <= W_IDLE;
            s_axi.axi_bvalid  <= 1'b0;
            s_axi.axi_awready <= 1'b1;
            s_axi.axi_wready  <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: capture data on AR handshake (pre-commit value), hold R until accepted
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      rd_state          <= R_IDLE;
      s_axi.axi_arready <= 1'b0;
      s_axi.axi_rvalid  <= 1'b0;
      s_axi.axi_rdata   <= '0;
      s_axi.axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state          <= R_DATA;
            s_axi.axi_arready <= 1'b0;
            s_axi.axi_rvalid  <= 1'b1;
            s_axi.axi_rdata   <= ar_ok ? regs[ar_idx] : 32'h0;
            s_axi.axi_rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            s_axi.axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.axi_rready) begin
            rd_state          <= R_IDLE;
            s_axi.axi_rvalid  <= 1'b0;
            s_axi.axi_arready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
